// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types and defaults for the miss/refill path ID pool.
// Pure declarations: no logic, no latency, no backpressure.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_N_ID = 8;

  function automatic int unsigned hpdcache_id_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  localparam int unsigned HPDCACHE_ID_W = hpdcache_id_width(HPDCACHE_N_ID);

  typedef logic [HPDCACHE_ID_W-1:0] hpdcache_id_t;

endpackage

// File: rtl/hpdcache_rrarb.sv
// N_REQ-way round-robin arbiter, one-hot combinational grant (0 cycles).
// No grant while ready_i is low; priority pointer moves past the winner only on a grant.
module hpdcache_rrarb #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             ready_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;

  // Scan from the priority pointer upwards, wrapping, and take the first request.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % N_REQ;
      if (ready_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PTR_W'((idx + 1) % N_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hpdcache_id_allocator.sv
// Transaction-ID pool: circular free-list shared by N_REQ requesters; grant is combinational (0 cycles).
// Grants stall on hold_i or an empty list; releases are always accepted, counters update next cycle.
module hpdcache_id_allocator
  import hpdcache_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned N_ID  = HPDCACHE_N_ID,
  localparam int unsigned ID_W  = hpdcache_id_width(N_ID),
  localparam int unsigned CNT_W = $clog2(N_ID + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] alloc_req_i,
  output logic [N_REQ-1:0] alloc_gnt_o,
  output logic [ID_W-1:0]  alloc_id_o,
  input  logic             hold_i,
  input  logic             rel_valid_i,
  input  logic [ID_W-1:0]  rel_id_i,
  output logic [CNT_W-1:0] free_cnt_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_ID - 1);

  logic [ID_W-1:0]      fifo_q [N_ID];
  logic [ID_W-1:0]      head_q;
  logic [ID_W-1:0]      tail_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 empty_q;
  logic                 err_q;
  logic [N_ID-1:0]      inuse_q;
  logic [2**ID_W-1:0]   inuse_pad;
  logic                 grant_ok;
  logic                 do_alloc;
  logic                 rel_ok;

  // Gating on rst_ni keeps the grant low for the whole reset window.
  assign grant_ok = rst_ni && !hold_i && (cnt_q != '0);

  hpdcache_rrarb #(
    .N_REQ (N_REQ)
  ) u_rrarb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (alloc_req_i),
    .ready_i (grant_ok),
    .gnt_o   (alloc_gnt_o)
  );

  assign do_alloc   = |alloc_gnt_o;
  assign alloc_id_o = fifo_q[head_q];

  // Padding bits stay zero, so any ID at or above N_ID reads as "not in use".
  always_comb begin
    inuse_pad           = '0;
    inuse_pad[N_ID-1:0] = inuse_q;
  end

  assign rel_ok = rel_valid_i && inuse_pad[rel_id_i];

  always_comb begin
    cnt_d = cnt_q;
    if (do_alloc && !rel_ok) begin
      cnt_d = cnt_q - 1'b1;
    end else if (rel_ok && !do_alloc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_ID; k++) begin
        fifo_q[k] <= ID_W'(k);
      end
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= CNT_W'(N_ID);
      empty_q <= 1'b0;
      err_q   <= 1'b0;
      inuse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      if (do_alloc) begin
        head_q              <= (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
        inuse_q[alloc_id_o] <= 1'b1;
      end
      // A released ID cannot be at head, so it never collides with the grant above.
      if (rel_ok) begin
        fifo_q[tail_q]    <= rel_id_i;
        tail_q            <= (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        inuse_q[rel_id_i] <= 1'b0;
      end
      if (rel_valid_i && !rel_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign free_cnt_o = cnt_q;
  assign empty_o    = empty_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_hpdcache_id_allocator.sv
// Scoreboard bench for hpdcache_id_allocator: expected grants queued at stimulus time, checked at negedge.
module tb_hpdcache_id_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alloc_req;
  logic [3:0] alloc_gnt;
  logic [2:0] alloc_id;
  logic       hold;
  logic       rel_valid;
  logic [2:0] rel_id;
  logic [3:0] free_cnt;
  logic       empty;
  logic       err;

  logic [0:0] req6;
  logic [0:0] gnt6;
  logic [2:0] id6;
  logic       rel6_valid;
  logic [2:0] rel6_id;
  logic [2:0] cnt6;
  logic       empty6;
  logic       err6;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int r;
    int id;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hpdcache_id_allocator #(.N_REQ(4), .N_ID(8)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .alloc_req_i (alloc_req),
    .alloc_gnt_o (alloc_gnt),
    .alloc_id_o  (alloc_id),
    .hold_i      (hold),
    .rel_valid_i (rel_valid),
    .rel_id_i    (rel_id),
    .free_cnt_o  (free_cnt),
    .empty_o     (empty),
    .err_o       (err)
  );

  // Non-power-of-two pool, so an out-of-range ID is representable on rel_id_i.
  hpdcache_id_allocator #(.N_REQ(1), .N_ID(6)) u_dut6 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .alloc_req_i (req6),
    .alloc_gnt_o (gnt6),
    .alloc_id_o  (id6),
    .hold_i      (1'b0),
    .rel_valid_i (rel6_valid),
    .rel_id_i    (rel6_id),
    .free_cnt_o  (cnt6),
    .empty_o     (empty6),
    .err_o       (err6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input int id);
    exp_t e;
    e.r  = r;
    e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (alloc_gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", 32'(alloc_gnt), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("gnt_onehot", 32'(alloc_gnt), 32'(1) << e.r);
        chk("gnt_id", 32'(alloc_id), 32'(e.id));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    alloc_req  = 4'hF;
    hold       = 1'b0;
    rel_valid  = 1'b0;
    rel_id     = '0;
    req6       = '0;
    rel6_valid = 1'b0;
    rel6_id    = '0;

    #12;
    chk("rst_gnt", 32'(alloc_gnt), 0);
    chk("rst_id", 32'(alloc_id), 0);
    chk("rst_free_cnt", 32'(free_cnt), 8);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_err", 32'(err), 0);
    alloc_req = '0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Single requester drains the whole pool in order.
    for (int k = 0; k < 8; k++) push(0, k);
    alloc_req = 4'b0001;
    cyc(8);
    chk("drain_free_cnt", 32'(free_cnt), 0);
    chk("drain_empty", 32'(empty), 1);
    cyc(2);
    alloc_req = '0;
    chk("drain_sb", 32'(exp_q.size()), 0);

    // All requesters: strict rotation, two IDs each.
    do_reset();
    for (int k = 0; k < 8; k++) push(k % 4, k);
    alloc_req = 4'hF;
    cyc(10);
    alloc_req = '0;
    chk("rr_sb", 32'(exp_q.size()), 0);
    chk("rr_empty", 32'(empty), 1);

    // Release into an empty list: not bypassed, grantable one cycle later.
    alloc_req = 4'b0010;
    rel_valid = 1'b1;
    rel_id    = 3'd5;
    cyc(1);
    rel_valid = 1'b0;
    chk("rel_empty_free_cnt", 32'(free_cnt), 1);
    chk("rel_empty_flag", 32'(empty), 0);
    push(1, 5);
    cyc(1);
    alloc_req = '0;
    chk("regrant_free_cnt", 32'(free_cnt), 0);
    chk("regrant_sb", 32'(exp_q.size()), 0);

    // Double release of ID 3: second one is illegal and must not touch the list.
    rel_valid = 1'b1;
    rel_id    = 3'd3;
    cyc(1);
    chk("legal_rel_cnt", 32'(free_cnt), 1);
    chk("legal_rel_err", 32'(err), 0);
    cyc(1);
    rel_valid = 1'b0;
    chk("illegal_rel_err", 32'(err), 1);
    chk("illegal_rel_cnt", 32'(free_cnt), 1);
    cyc(2);
    chk("err_sticky", 32'(err), 1);
    push(2, 3);
    alloc_req = 4'b0100;
    cyc(1);
    alloc_req = '0;
    chk("after_illegal_cnt", 32'(free_cnt), 0);
    chk("after_illegal_sb", 32'(exp_q.size()), 0);

    // Out-of-range ID on the 6-entry pool.
    rel6_valid = 1'b1;
    rel6_id    = 3'd7;
    cyc(1);
    rel6_valid = 1'b0;
    chk("oor_err", 32'(err6), 1);
    chk("oor_cnt", 32'(cnt6), 6);

    // Hold blocks grants, releases still land, rotation resumes at the pointer.
    do_reset();
    chk("reset_clears_err", 32'(err), 0);
    push(0, 0);
    alloc_req = 4'b0001;
    cyc(1);
    alloc_req = '0;
    hold      = 1'b1;
    alloc_req = 4'hF;
    cyc(3);
    chk("hold_cnt", 32'(free_cnt), 7);
    rel_valid = 1'b1;
    rel_id    = 3'd0;
    cyc(1);
    rel_valid = 1'b0;
    chk("hold_rel_cnt", 32'(free_cnt), 8);
    cyc(1);
    push(1, 1);
    push(2, 2);
    hold = 1'b0;
    cyc(2);
    alloc_req = '0;
    chk("unhold_cnt", 32'(free_cnt), 6);
    chk("unhold_sb", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a cycle forgets outstanding IDs.
    do_reset();
    for (int k = 0; k < 5; k++) push(0, k);
    alloc_req = 4'b0001;
    cyc(5);
    chk("pre_arst_cnt", 32'(free_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(alloc_gnt), 0);
    chk("arst_id", 32'(alloc_id), 0);
    chk("arst_free_cnt", 32'(free_cnt), 8);
    chk("arst_empty", 32'(empty), 0);
    cyc(1);
    rst_n = 1'b1;
    push(0, 0);
    cyc(1);
    alloc_req = '0;
    chk("post_arst_cnt", 32'(free_cnt), 7);
    cyc(1);
    chk("final_sb", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
